// File: rtl/busy_ctr_multi.sv
// Multi-channel busy counter: NUM_CHAN down-counters with a round-robin done handshake.
// Optional macro BUSYCTR_PAUSE_EN adds a 'pause' input that freezes every counter.
module busy_ctr_multi #(
    parameter  int NUM_CHAN   = 4,
    parameter  int CNT_WIDTH  = 8,
    parameter  int MAX_AMOUNT = 22,
    localparam int CW         = $clog2(NUM_CHAN)
) (
    input  logic                 CLK,
    input  logic                 RST,
`ifdef BUSYCTR_PAUSE_EN
    input  logic                 pause,
`endif
    input  logic                 start__ENA,
    input  logic [CW-1:0]        start__chan,
    input  logic [CNT_WIDTH-1:0] start__amount,
    output logic                 start__RDY,
    input  logic                 abort__ENA,
    input  logic [CW-1:0]        abort__chan,
    output logic                 abort__RDY,
    output logic [NUM_CHAN-1:0]  busy,
    output logic                 done__ENA,
    output logic [CW-1:0]        done__chan,
    input  logic                 done__RDY
);

    logic [CNT_WIDTH-1:0] count_r     [NUM_CHAN];
    logic [CNT_WIDTH-1:0] count_nxt_s [NUM_CHAN];
    logic [NUM_CHAN-1:0]  pend_r;
    logic [NUM_CHAN-1:0]  pend_nxt_s;
    // arm_r marks a zero-amount start: it becomes a pending event one edge later
    logic [NUM_CHAN-1:0]  arm_r;
    logic [NUM_CHAN-1:0]  arm_nxt_s;
    logic [NUM_CHAN-1:0]  busy_r;
    logic [CW-1:0]        rr_r;
    logic [CW-1:0]        rr_nxt_s;
    logic [CW-1:0]        gnt_chan_r;
    logic [CW-1:0]        gnt_chan_nxt_s;
    logic                 gnt_vld_r;
    logic                 gnt_vld_nxt_s;

    logic [CNT_WIDTH-1:0] amount_s;
    logic [(1<<CW)-1:0]   idle_s;
    logic                 start_rdy_s;
    logic                 pause_s;
    logic                 xfer_s;
    logic [NUM_CHAN-1:0]  start_hit_s;
    logic [NUM_CHAN-1:0]  abort_hit_s;
    logic [NUM_CHAN-1:0]  xfer_hit_s;
    logic [NUM_CHAN-1:0]  cand_s;
    logic                 found_s;
    int                   idx_s;

`ifdef BUSYCTR_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    assign xfer_s     = gnt_vld_r && done__RDY;
    assign start__RDY = start_rdy_s;
    assign abort__RDY = 1'b1;
    assign busy       = busy_r;
    assign done__ENA  = gnt_vld_r;
    assign done__chan = gnt_chan_r;

    // Clamp the requested amount and work out which channel can accept a start.
    always_comb begin
        amount_s = start__amount;
        if (start__amount > CNT_WIDTH'(MAX_AMOUNT)) begin
            amount_s = CNT_WIDTH'(MAX_AMOUNT);
        end else begin
            amount_s = start__amount;
        end
        idle_s = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            idle_s[c] = (count_r[c] == '0) && !pend_r[c] && !arm_r[c];
        end
        start_rdy_s = idle_s[start__chan];
    end

    // Per-channel decode of starts, aborts and done transfers with their priorities.
    always_comb begin
        start_hit_s = '0;
        abort_hit_s = '0;
        xfer_hit_s  = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            xfer_hit_s[c]  = xfer_s && (gnt_chan_r == CW'(c));
            // a transfer on the same channel wins over an abort
            abort_hit_s[c] = abort__ENA && (abort__chan == CW'(c)) && !xfer_hit_s[c];
            // an abort on the same channel wins over a start
            start_hit_s[c] = start__ENA && start_rdy_s && (start__chan == CW'(c))
                             && !(abort__ENA && (abort__chan == CW'(c)));
        end
    end

    // Next-state of counters, pending flags and zero-amount arm flags.
    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            count_nxt_s[c] = count_r[c];
            pend_nxt_s[c]  = pend_r[c];
            arm_nxt_s[c]   = arm_r[c];
            if (abort_hit_s[c]) begin
                count_nxt_s[c] = '0;
                pend_nxt_s[c]  = 1'b0;
                arm_nxt_s[c]   = 1'b0;
            end else if (start_hit_s[c]) begin
                count_nxt_s[c] = amount_s;
                arm_nxt_s[c]   = (amount_s == '0);
            end else if (arm_r[c]) begin
                arm_nxt_s[c]   = 1'b0;
                pend_nxt_s[c]  = 1'b1;
            end else if ((count_r[c] != '0) && !pause_s) begin
                count_nxt_s[c] = count_r[c] - CNT_WIDTH'(1);
                if (count_r[c] == CNT_WIDTH'(1)) begin
                    pend_nxt_s[c] = 1'b1;
                end else begin
                    pend_nxt_s[c] = pend_r[c];
                end
            end else if (xfer_hit_s[c]) begin
                pend_nxt_s[c]  = 1'b0;
            end else begin
                count_nxt_s[c] = count_r[c];
            end
        end
    end

    // Round-robin arbiter: one registered grant, held until transferred or aborted.
    always_comb begin
        rr_nxt_s       = rr_r;
        gnt_vld_nxt_s  = gnt_vld_r;
        gnt_chan_nxt_s = gnt_chan_r;
        cand_s         = pend_r & ~abort_hit_s;
        found_s        = 1'b0;
        idx_s          = 0;
        if (xfer_s) begin
            gnt_vld_nxt_s = 1'b0;
            if (int'(gnt_chan_r) == NUM_CHAN - 1) begin
                rr_nxt_s = '0;
            end else begin
                rr_nxt_s = gnt_chan_r + CW'(1);
            end
        end else if (gnt_vld_r) begin
            if (abort_hit_s[gnt_chan_r]) begin
                gnt_vld_nxt_s = 1'b0;
            end else begin
                gnt_vld_nxt_s = 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                idx_s = (int'(rr_r) + i) % NUM_CHAN;
                if (!found_s && cand_s[idx_s]) begin
                    found_s        = 1'b1;
                    gnt_chan_nxt_s = CW'(idx_s);
                end else begin
                    found_s = found_s;
                end
            end
            gnt_vld_nxt_s = found_s;
        end
    end

    // State registers; busy is registered from the next count value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                count_r[c] <= '0;
            end
            pend_r     <= '0;
            arm_r      <= '0;
            busy_r     <= '0;
            rr_r       <= '0;
            gnt_vld_r  <= 1'b0;
            gnt_chan_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                count_r[c] <= count_nxt_s[c];
                busy_r[c]  <= (count_nxt_s[c] != '0);
            end
            pend_r     <= pend_nxt_s;
            arm_r      <= arm_nxt_s;
            rr_r       <= rr_nxt_s;
            gnt_vld_r  <= gnt_vld_nxt_s;
            gnt_chan_r <= gnt_chan_nxt_s;
        end
    end

endmodule

// File: tb/tb_busy_ctr_multi.sv
// Scoreboard bench for busy_ctr_multi: expected done channels are queued when starts are driven.
module tb_busy_ctr_multi;

    logic       CLK = 1'b0;
    logic       RST;
`ifdef BUSYCTR_PAUSE_EN
    logic       pause;
`endif
    logic       start__ENA;
    logic [1:0] start__chan;
    logic [7:0] start__amount;
    logic       start__RDY;
    logic       abort__ENA;
    logic [1:0] abort__chan;
    logic       abort__RDY;
    logic [3:0] busy;
    logic       done__ENA;
    logic [1:0] done__chan;
    logic       done__RDY;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    busy_ctr_multi #(.NUM_CHAN(4), .CNT_WIDTH(8), .MAX_AMOUNT(22)) dut (
`ifdef BUSYCTR_PAUSE_EN
        .pause(pause),
`endif
        .CLK(CLK),
        .RST(RST),
        .start__ENA(start__ENA),
        .start__chan(start__chan),
        .start__amount(start__amount),
        .start__RDY(start__RDY),
        .abort__ENA(abort__ENA),
        .abort__chan(abort__chan),
        .abort__RDY(abort__RDY),
        .busy(busy),
        .done__ENA(done__ENA),
        .done__chan(done__chan),
        .done__RDY(done__RDY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Score a transfer about to happen at the coming edge, then advance one cycle.
    task automatic tick();
        int e;
        if (done__ENA === 1'b1 && done__RDY === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got chan %0d, expected no done", done__chan);
            end else begin
                e = exp_q.pop_front();
                if (int'(done__chan) !== e) begin
                    errors++;
                    $display("FAIL done_chan: got %0d, expected %0d", done__chan, e);
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_empty(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d dones outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_start(input int ch, input int amt, input logic exp_rdy, input string name);
        start__ENA    = 1'b1;
        start__chan   = 2'(ch);
        start__amount = 8'(amt);
        #1;
        checks++;
        if (start__RDY !== exp_rdy) begin
            errors++;
            $display("FAIL %s: start__RDY=%b, expected %b", name, start__RDY, exp_rdy);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        start__chan = 2'd0;
        #1;
        checks++;
        if (busy !== 4'b0000 || done__ENA !== 1'b0 || done__chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_outs: busy=%b ena=%b chan=%0d, expected 0000 0 0", busy, done__ENA, done__chan);
        end
        checks++;
        if (start__RDY !== 1'b1 || abort__RDY !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: start=%b abort=%b, expected 1 1", start__RDY, abort__RDY);
        end
        @(negedge CLK);
        RST = 1'b0;
        tick();
        do_start(1, 5, 1'b1, "reset_start_rdy");
        tick();
        start__ENA = 1'b0;
        tick();
        checks++;
        if (busy !== 4'b0010) begin
            errors++;
            $display("FAIL reset_busy_pre: busy=%b, expected 0010", busy);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (busy !== 4'b0000 || done__ENA !== 1'b0 || start__RDY !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: busy=%b ena=%b rdy=%b, expected 0000 0 1", busy, done__ENA, start__RDY);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (10) tick();
        checks++;
        if (done__ENA !== 1'b0 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_replay: ena=%b busy=%b, expected 0 0000", done__ENA, busy);
        end
    endtask

    task automatic test_single();
        int bc = 0;
        int fd = -1;
        do_start(2, 3, 1'b1, "single_rdy");
        exp_q.push_back(2);
        tick();
        start__ENA  = 1'b0;
        start__chan = 2'd2;
        for (int k = 0; k < 12; k++) begin
            if (busy[2] === 1'b1) bc++;
            if (done__ENA === 1'b1 && fd < 0) fd = k;
            if (k == 5) begin
                checks++;
                if (start__RDY !== 1'b1) begin
                    errors++;
                    $display("FAIL single_restart_rdy: start__RDY=%b, expected 1", start__RDY);
                end
            end
            tick();
        end
        checks++;
        if (bc != 3) begin
            errors++;
            $display("FAIL single_busy_len: got %0d cycles, expected 3", bc);
        end
        checks++;
        if (fd != 4) begin
            errors++;
            $display("FAIL single_done_time: got %0d, expected 4", fd);
        end
        wait_empty(1, "single_drain");
    endtask

    task automatic test_back_to_back();
        done__RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_start(i, 4, 1'b1, "b2b_rdy");
            exp_q.push_back(i);
            tick();
        end
        start__ENA = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done__ENA === 1'b1) begin
                checks++;
                if (done__chan !== 2'd0) begin
                    errors++;
                    $display("FAIL b2b_stall_chan: got %0d, expected 0", done__chan);
                end
            end
            tick();
        end
        checks++;
        if (done__ENA !== 1'b1 || done__chan !== 2'd0) begin
            errors++;
            $display("FAIL b2b_held: ena=%b chan=%0d, expected 1 0", done__ENA, done__chan);
        end
        done__RDY = 1'b1;
        wait_empty(20, "b2b_drain");
    endtask

    task automatic test_clamp();
        int bc1 = 0;
        int bc3 = 0;
        int fd3 = -1;
        do_start(3, 0, 1'b1, "zero_rdy");
        exp_q.push_back(3);
        exp_q.push_back(1);
        tick();
        for (int k = 0; k < 40; k++) begin
            if (busy[1] === 1'b1) bc1++;
            if (busy[3] === 1'b1) bc3++;
            if (done__ENA === 1'b1 && done__chan === 2'd3 && fd3 < 0) fd3 = k;
            if (k == 0) do_start(1, 40, 1'b1, "clamp_rdy");
            else if (k == 1) do_start(1, 7, 1'b0, "restart_busy_rdy");
            else start__ENA = 1'b0;
            tick();
        end
        start__ENA = 1'b0;
        checks++;
        if (bc1 != 22) begin
            errors++;
            $display("FAIL clamp_busy_len: got %0d, expected 22", bc1);
        end
        checks++;
        if (bc3 != 0) begin
            errors++;
            $display("FAIL zero_busy: got %0d cycles, expected 0", bc3);
        end
        checks++;
        if (fd3 != 2) begin
            errors++;
            $display("FAIL zero_done_time: got %0d, expected 2", fd3);
        end
        wait_empty(1, "clamp_drain");
    endtask

    task automatic test_abort();
        int n = 0;
        do_start(2, 6, 1'b1, "abort_start_rdy");
        tick();
        start__ENA = 1'b0;
        tick();
        abort__ENA  = 1'b1;
        abort__chan = 2'd2;
        tick();
        abort__ENA = 1'b0;
        checks++;
        if (busy !== 4'b0000) begin
            errors++;
            $display("FAIL abort_busy: busy=%b, expected 0000", busy);
        end
        repeat (12) tick();
        done__RDY = 1'b0;
        do_start(0, 1, 1'b1, "abort_gnt_rdy");
        tick();
        start__ENA = 1'b0;
        while (done__ENA !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (done__ENA !== 1'b1 || done__chan !== 2'd0) begin
            errors++;
            $display("FAIL abort_pre_grant: ena=%b chan=%0d, expected 1 0", done__ENA, done__chan);
        end
        abort__ENA  = 1'b1;
        abort__chan = 2'd0;
        tick();
        abort__ENA = 1'b0;
        checks++;
        if (done__ENA !== 1'b0) begin
            errors++;
            $display("FAIL abort_grant_drop: ena=%b, expected 0", done__ENA);
        end
        done__RDY = 1'b1;
        repeat (5) tick();
        do_start(1, 3, 1'b1, "rr_rdy1");
        exp_q.push_back(3);
        exp_q.push_back(1);
        tick();
        do_start(3, 2, 1'b1, "rr_rdy3");
        tick();
        start__ENA = 1'b0;
        wait_empty(20, "rr_order_drain");
    endtask

`ifdef BUSYCTR_PAUSE_EN
    task automatic test_pause();
        int bc = 0;
        do_start(0, 5, 1'b1, "pause_rdy");
        exp_q.push_back(0);
        tick();
        start__ENA = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (busy[0] === 1'b1) bc++;
            pause = (k >= 1 && k <= 3);
            tick();
        end
        pause = 1'b0;
        checks++;
        if (bc != 8) begin
            errors++;
            $display("FAIL pause_busy_len: got %0d, expected 8", bc);
        end
        wait_empty(5, "pause_drain");
    endtask
`endif

    initial begin
        RST           = 1'b1;
`ifdef BUSYCTR_PAUSE_EN
        pause         = 1'b0;
`endif
        start__ENA    = 1'b0;
        start__chan   = 2'd0;
        start__amount = 8'd0;
        abort__ENA    = 1'b0;
        abort__chan   = 2'd0;
        done__RDY     = 1'b1;
        @(negedge CLK);
        test_reset();
        test_single();
        test_back_to_back();
        test_clamp();
        test_abort();
`ifdef BUSYCTR_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/busy_ctr_multi.md
# busy_ctr_multi

Multi-channel successor to the single busy counter: NUM_CHAN independent down-counters, each started with a per-request amount, each reporting busy while counting and posting a completion event on a shared round-robin done handshake. It sits between a command issuer and the consumer that must learn when each channel's busy interval has expired.

## Interface

Parameters:
- NUM_CHAN, 4, number of channels (≥2).
- CNT_WIDTH, 8, counter width in bits.
- MAX_AMOUNT, 22, clamp for requested amount (< 2^CNT_WIDTH).
- Derived: CW = $clog2(NUM_CHAN).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- start__ENA  in  1  start request.
- start$chan  in  CW  target channel.
- start$amount  in  CNT_WIDTH  busy duration in cycles.
- start__RDY  out  1  target channel idle: count[start$chan]==0 and no pending done on it.
- abort__ENA  in  1  cancel a channel.
- abort$chan  in  CW  channel to cancel.
- abort__RDY  out  1  constant 1.
- busy  out  NUM_CHAN  busy[c] = (count[c] != 0).
- done__ENA  out  1  completion event offered.
- done$chan  out  CW  channel that completed.
- done__RDY  in  1  consumer accepts.

## Operation

- Per channel: count[c] (CNT_WIDTH), pend[c] (1). Shared: rr pointer (CW), grant valid + grant chan registers.
- start accepted when start__ENA && start__RDY; a start__ENA without RDY is ignored (caller error, no state change).
- Loaded value = min(start$amount, MAX_AMOUNT).
- Amount 0: count stays 0, pend set at the next edge.
- Each cycle count[c]!=0 decrements by 1; on the 1→0 transition pend[c] is set on the same edge.
- Arbiter: if no grant valid and any pend, register grant = first pending channel scanning upward from rr with wrap-around. Grant is held stable until accepted.
- done__ENA = grant valid; done$chan = grant chan.
- Transfer = done__ENA && done__RDY. It clears pend[grant], invalidates the grant and sets rr = grant+1 mod NUM_CHAN. A new grant may be registered on the following edge.
- abort on channel c clears count[c] and pend[c]. If c is currently granted, the grant is invalidated and no done is delivered. Aborting an idle channel is a no-op.
- Simultaneous abort and start on the same channel: abort wins, start discarded.
- Simultaneous abort and done transfer on the same channel: the transfer counts as delivered; the abort is a no-op.
- Starts, aborts and expiries on different channels in the same cycle are all honoured.

## Timing

- Reset values: count 0, pend 0, rr 0, grant invalid. Outputs: busy 0, done__ENA 0, done$chan 0, start__RDY 1, abort__RDY 1.
- RST assertion mid-count drops all counts and pending events immediately; nothing is replayed.
- Start accepted at edge t with amount N>0: busy high from t+1 for exactly N cycles; pend set at edge t+N; done__ENA earliest at t+N+1.
- Amount 0: pend at t+1, done__ENA earliest at t+2, busy never high.
- start__RDY is combinational from start$chan and registered state; it has no path from start__ENA.
- Channel restartable on the cycle after its done transfer.

## Configuration

- BUSYCTR_PAUSE_EN:
  - Defined: adds input pause (1 bit); while high all counters hold. Starts, aborts and the done handshake still operate, and loaded values are not decremented until pause drops.
  - Undefined: no pause port; counters always decrement.

## Test plan

- Reset with RST pulsed mid-count on ch1 (amount 5) -> busy=0, done__ENA=0 immediately, start__RDY=1, no later done.
- Start ch2 amount 3, done__RDY=1 -> busy[2] high exactly 3 cycles; done__ENA with done$chan=2 one cycle after busy falls; single transfer.
- Start ch0..3 same amount 4 on consecutive cycles with done__RDY=0 for 10 cycles, then 1 -> done$chan order 0,1,2,3; grant held stable while stalled.
- Start ch1 amount 40 (MAX_AMOUNT 22) -> busy 22 cycles. Start ch3 amount 0 -> done in 2 cycles, busy never high. Restart ch1 while busy -> start__RDY=0, ignored.
- Abort ch2 at cycle 2 of amount 6, and abort a granted-but-stalled channel -> no done for either; rr unchanged.
- With BUSYCTR_PAUSE_EN: start amount 5, pause 3 cycles mid-count -> busy lasts 8 cycles.
